// File: rtl/alu_seq_core.sv
`timescale 1ns/1ps
// Sequential ALU core: single-cycle add/sub/logic/shift plus iterative unsigned multiply/divide,
// valid/ready handshake on both sides, result and flags held in registers until consumed.
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       flags
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [4:0]       flags_q, flags_d;

  function automatic logic [4:0] mk_flags(input logic [WIDTH-1:0] lo, input logic c,
                                          input logic v, input logic err);
    return {err, lo[WIDTH-1], v, c, (lo == '0)};
  endfunction

  // Single-cycle datapath, evaluated on the request inputs at the accept edge.
  logic [SW-1:0]          shamt;
  logic                   sh_big;
  logic [WIDTH:0]         sum_ext;
  logic [WIDTH-1:0]       diff;
  logic [WIDTH:0]         shl_ext;
  logic [WIDTH:0]         shr_ext;
  logic signed [WIDTH:0]  sra_ext;
  logic [WIDTH-1:0]       sc_lo, sc_hi;
  logic                   sc_c, sc_v, sc_err;

  assign shamt   = b[SW-1:0];
  assign sh_big  = |(b >> SW);
  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign diff    = a - b;
  assign shl_ext = {1'b0, a} << shamt;
  assign shr_ext = {a, 1'b0} >> shamt;
  assign sra_ext = $signed({a, 1'b0}) >>> shamt;

  always_comb begin
    sc_lo  = '0;
    sc_hi  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    case (op)
      4'd0: begin
        sc_lo = sum_ext[WIDTH-1:0];
        sc_c  = sum_ext[WIDTH];
        sc_v  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        sc_lo = diff;
        sc_c  = (a < b);
        sc_v  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: sc_lo = a & b;
      4'd3: sc_lo = a | b;
      4'd4: sc_lo = a ^ b;
      // The extra bit of each extended shift captures the last bit shifted out.
      4'd5: if (!sh_big) begin
        sc_lo = shl_ext[WIDTH-1:0];
        sc_c  = shl_ext[WIDTH];
      end
      4'd6: if (!sh_big) begin
        sc_lo = shr_ext[WIDTH:1];
        sc_c  = shr_ext[0];
      end
      4'd7: begin
        if (sh_big) begin
          sc_lo = {WIDTH{a[WIDTH-1]}};
        end else begin
          sc_lo = sra_ext[WIDTH:1];
          sc_c  = sra_ext[0];
        end
      end
      4'd9: begin
        sc_lo  = '1;
        sc_hi  = a;
        sc_err = 1'b1;
      end
      4'd8: ;
      default: sc_err = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide on {hi_q, lo_q}.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign rem_sh  = {hi_q, lo_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, b_q};

  always_comb begin
    if (is_div_q) begin
      if (rem_sh >= {1'b0, b_q}) begin
        step_hi = rem_sub[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (op == 4'd8 || (op == 4'd9 && b != '0)) begin
          state_d  = CALC;
          is_div_d = op[0];
          b_d      = b;
          hi_d     = '0;
          lo_d     = a;
          cnt_d    = '0;
        end else begin
          state_d  = DONE;
          res_lo_d = sc_lo;
          res_hi_d = sc_hi;
          flags_d  = mk_flags(sc_lo, sc_c, sc_v, sc_err);
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = DONE;
          res_lo_d = step_lo;
          res_hi_d = step_hi;
          flags_d  = mk_flags(step_lo, !is_div_q && (step_hi != '0), 1'b0, 1'b0);
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_alu_seq_core.sv
`timescale 1ns/1ps
// Directed bench for alu_seq_core at WIDTH=8: vector table plus backpressure and mid-CALC reset.
module tb_alu_seq_core;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result_lo, result_hi;
  logic [4:0]   flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_lo(result_lo), .result_hi(result_hi), .flags(flags)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [4:0] fl;
    int         lat;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request with out_ready=1, scramble inputs after accept, wait for out_valid.
  task automatic run_op(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                        output int lat, output logic busy_ready);
    @(posedge clk); #1;
    op = o; a = aa; b = bb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    busy_ready = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int         lat;
    logic       busy;
    logic [7:0] hold_lo, hold_hi;
    logic [4:0] hold_fl;

    //            op     a      b      lo     hi     {E,N,V,C,Z} lat
    vecs[0]  = '{4'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b00011, 1};
    vecs[1]  = '{4'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 5'b00100, 1};
    vecs[2]  = '{4'd8, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b00010, 9};
    vecs[3]  = '{4'd9, 8'hC8, 8'h07, 8'h1C, 8'h04, 5'b00000, 9};
    vecs[4]  = '{4'd9, 8'h55, 8'h00, 8'hFF, 8'h55, 5'b11000, 1};
    vecs[5]  = '{4'd7, 8'h90, 8'h09, 8'hFF, 8'h00, 5'b01000, 1};
    vecs[6]  = '{4'hC, 8'h12, 8'h34, 8'h00, 8'h00, 5'b10001, 1};
    vecs[7]  = '{4'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000, 1};
    vecs[8]  = '{4'd3, 8'h0F, 8'h30, 8'h3F, 8'h00, 5'b00000, 1};
    vecs[9]  = '{4'd4, 8'hAA, 8'hAA, 8'h00, 8'h00, 5'b00001, 1};
    vecs[10] = '{4'd5, 8'h81, 8'h01, 8'h02, 8'h00, 5'b00010, 1};
    vecs[11] = '{4'd6, 8'h81, 8'h01, 8'h40, 8'h00, 5'b00010, 1};
    vecs[12] = '{4'd7, 8'h81, 8'h03, 8'hF0, 8'h00, 5'b01000, 1};
    vecs[13] = '{4'd5, 8'h55, 8'h00, 8'h55, 8'h00, 5'b00000, 1};
    vecs[14] = '{4'd6, 8'h80, 8'h08, 8'h00, 8'h00, 5'b00001, 1};
    vecs[15] = '{4'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b01100, 1};
    vecs[16] = '{4'd1, 8'h01, 8'h02, 8'hFF, 8'h00, 5'b01010, 1};
    vecs[17] = '{4'd8, 8'h0D, 8'h0B, 8'h8F, 8'h00, 5'b01000, 9};
    vecs[18] = '{4'd9, 8'h07, 8'h09, 8'h00, 8'h07, 5'b00001, 9};
    vecs[19] = '{4'd5, 8'h03, 8'h07, 8'h80, 8'h00, 5'b01010, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    @(posedge clk); #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result_lo", 32'(result_lo), 32'd0);
    chk("reset result_hi", 32'(result_hi), 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy);
      $display("vec %0d op=%0d a=%02h b=%02h -> lo=%02h hi=%02h flags=%05b lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, result_lo, result_hi, flags, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d result_lo", i), 32'(result_lo), 32'(vecs[i].lo));
      chk($sformatf("vec%0d result_hi", i), 32'(result_hi), 32'(vecs[i].hi));
      chk($sformatf("vec%0d flags", i), 32'(flags), 32'(vecs[i].fl));
      chk($sformatf("vec%0d in_ready busy", i), 32'(busy | in_ready), 32'd0);
    end

    // Backpressure: result must hold while out_ready is low.
    @(posedge clk); #1;
    op = 4'd0; a = 8'h12; b = 8'h34; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'hEE; b = 8'hEE;
    chk("bp out_valid", 32'(out_valid), 32'd1);
    hold_lo = 8'h46; hold_hi = 8'h00; hold_fl = 5'b00000;
    for (int c = 0; c < 5; c++) begin
      $display("bp cycle %0d: out_valid=%0b in_ready=%0b lo=%02h flags=%05b",
               c, out_valid, in_ready, result_lo, flags);
      chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d result_lo", c), 32'(result_lo), 32'(hold_lo));
      chk($sformatf("bp%0d result_hi", c), 32'(result_hi), 32'(hold_hi));
      chk($sformatf("bp%0d flags", c), 32'(flags), 32'(hold_fl));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    $display("bp release: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);

    // Reset partway through a multiply discards it.
    op = 4'd8; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid-calc out_valid", 32'(out_valid), 32'd0);
    chk("mid-calc in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("mid-calc reset: out_valid=%0b in_ready=%0b lo=%02h hi=%02h flags=%05b",
             out_valid, in_ready, result_lo, result_hi, flags);
    chk("rst2 out_valid", 32'(out_valid), 32'd0);
    chk("rst2 in_ready", 32'(in_ready), 32'd1);
    chk("rst2 result_lo", 32'(result_lo), 32'd0);
    chk("rst2 result_hi", 32'(result_hi), 32'd0);
    chk("rst2 flags", 32'(flags), 32'd0);

    run_op(4'd0, 8'h02, 8'h03, lat, busy);
    $display("post-reset ADD 02+03 -> lo=%02h lat=%0d", result_lo, lat);
    chk("post-reset latency", 32'(lat), 32'd1);
    chk("post-reset result_lo", 32'(result_lo), 32'h05);
    chk("post-reset flags", 32'(flags), 32'd0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised sequential ALU core: the next generation of the top-level ALU, generalised to any operand width. It adds valid/ready handshaking on both sides, multi-cycle unsigned multiply and divide, and a full flag set. It sits between the pin-level operand-capture logic and the output mux of the top level, and is also reusable standalone.

## Interface
- WIDTH, 8, operand width in bits (power of two, 4..32).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  core can accept a request.
- op  in  4  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- result_lo  out  WIDTH  primary result / product low half / quotient.
- result_hi  out  WIDTH  product high half / remainder; 0 for other ops.
- flags  out  5  {ERR, N, V, C, Z}.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR (logical), 7 SRA: shift amount = b as unsigned.
  - 8 MULU (multi-cycle), 9 DIVU (multi-cycle).
  - 10–15 illegal.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch op/a/b.
  - Single-cycle ops, illegal ops and DIVU with b==0 go to DONE.
  - MULU and DIVU with b!=0 go to CALC with iteration counter = 0.
- CALC:
  - One shift-add (MULU) or restoring-subtract (DIVU) step per cycle.
  - After WIDTH steps go to DONE.
  - Counter width is clog2(WIDTH)+1.
- DONE:
  - out_valid=1; result and flags registered and stable.
  - On out_ready go to IDLE.
  - in_ready=0 in CALC and DONE; no back-to-back acceptance.
- Flags:
  - Z = (result_lo==0).
  - N = result_lo[WIDTH-1].
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (a<b unsigned); V = signed overflow.
  - Logic ops: C=V=0.
  - Shifts: C = last bit shifted out; C=0 if amount==0 or amount>=WIDTH. V=0.
  - Shift amount >= WIDTH: SHL/SHR give 0, SRA gives all copies of a[WIDTH-1].
  - MULU: C = (result_hi!=0); V=0.
  - DIVU: C=V=0.
- ERR:
  - DIVU by 0: result_lo = all ones, result_hi = a, ERR=1.
  - Illegal opcode: result_lo=result_hi=0, ERR=1; Z=1, other flags 0.
  - ERR=0 otherwise.
- All arithmetic is modulo 2^WIDTH on result_lo; the multiply product is exactly 2·WIDTH bits.

## Timing
- Reset values (cycle after rst high): state IDLE, in_ready=1, out_valid=0, result_lo=0, result_hi=0, flags=0.
- rst dominates all other inputs in the same cycle, including mid-CALC and in DONE; any in-flight result is discarded.
- Handshakes:
  - A request transfers on a cycle with in_valid && in_ready.
  - A result transfers on a cycle with out_valid && out_ready.
- Latency, accept edge to out_valid high:
  - 1 cycle for single-cycle ops, illegal ops and divide-by-zero.
  - WIDTH+1 cycles for MULU and DIVU.
- out_valid is not combinationally dependent on out_ready; in_ready is a registered state decode.
- Under backpressure, result_lo, result_hi and flags do not change while out_valid=1 and out_ready=0.
- Inputs a, b and op are ignored when not transferring; they may change freely during CALC.
- Throughput: one op per latency+1 cycles minimum, since the DONE→IDLE transition costs one cycle.

## Test plan
All scenarios use WIDTH=8.
- ADD a=0xFF, b=0x01, out_ready=1 -> 1 cycle after accept: out_valid, result_lo=0x00, result_hi=0x00, flags Z=1 C=1 V=0 N=0 ERR=0.
- SUB a=0x80, b=0x01 -> result_lo=0x7F, V=1, C=0, N=0, Z=0.
- MULU a=0xFF, b=0xFF -> exactly 9 cycles after accept: result_hi=0xFE, result_lo=0x01, C=1; in_ready=0 throughout.
- DIVU a=0xC8, b=0x07 -> after 9 cycles: result_lo=0x1C, result_hi=0x04, ERR=0. Then DIVU a=0x55, b=0x00 -> after 1 cycle: result_lo=0xFF, result_hi=0x55, ERR=1.
- SRA a=0x90, b=0x09 -> result_lo=0xFF, C=0. Then op=0xC -> result_lo=0x00, ERR=1, Z=1.
- Backpressure and reset:
  - ADD with out_ready=0 for 5 cycles -> outputs stable, in_ready=0; out_ready=1 -> out_valid drops the next cycle, in_ready=1.
  - rst pulsed at CALC step 4 of a MULU -> next cycle out_valid=0, in_ready=1, all outputs 0; a following ADD 0x02+0x03 returns 0x05.
